comparador_pg: RTL and testbench
================================

# comparador_pg

Power-good window comparator. Samples a real-valued supply voltage each clock, checks it against a fixed min/max window, and drives a registered, deglitched power-good flag. Sits at the supply-monitoring boundary of the design and feeds power-good to reset/sequencing logic. Behavioural model: the `VDD` input is `shortreal`, not synthesizable.

## Interface
Parameters:
- `VDD_MIN` (shortreal), default 3.7 — lower window threshold, volts, inclusive.
- `VDD_MAX` (shortreal), default 4.3 — upper window threshold, volts, inclusive.
- `PG_DLY` (int), default 16 — consecutive in-window samples required before `pg` asserts; legal range 1..255.
- `HYST` (shortreal), default 0.1 — hysteresis margin, volts; used only when `COMPARADOR_HYST_EN` is defined.

Ports:
- `clk`, input, 1 — single clock; all state updates on its rising edge.
- `arst_n`, input, 1 — reset.
  - One clock; reset is synchronous and active-high.
  - Reset is sampled only on the rising edge of `clk`; the port keeps the codebase name `arst_n`.
- `VDD`, input, shortreal — supply voltage under test.
- `pg`, output, 1 — power good, registered.

## Operation
- `in_win` (combinational):
  - Without hysteresis: `VDD_MIN <= VDD <= VDD_MAX`.
  - Boundaries are inclusive: `VDD == 3.7` and `VDD == 4.3` are in-window.
- Three states:
  - `PG_LOW`: `pg = 0`.
  - `PG_WAIT`: `pg = 0`, 8-bit counter `cnt` active.
  - `PG_OK`: `pg = 1`.
- State transitions, evaluated each rising edge with reset low:
  - `PG_LOW` → `PG_WAIT` if `in_win`; `cnt` is set to 1.
  - `PG_WAIT`:
    - If `!in_win`: → `PG_LOW`, `cnt` = 0.
    - Else if `cnt == PG_DLY`: → `PG_OK`.
    - Else: `cnt` increments.
  - `PG_OK` → `PG_LOW` on the first `!in_win` sample; `cnt` = 0.
- `PG_DLY == 1`: `PG_WAIT` lasts exactly one cycle.
- Any out-of-window sample during `PG_WAIT` restarts qualification from zero. Glitches shorter than `PG_DLY` cycles never assert `pg`.
- `VDD` NaN or negative: treated as out-of-window.
- `cnt` saturates and never wraps; it cannot exceed `PG_DLY`.

## Timing
- Reset:
  - `arst_n == 1` at a rising edge forces state `PG_LOW`, `cnt = 0`, `pg = 0` at that edge.
  - Reset has priority over all transitions.
  - Reset asserted mid-qualification or while in `PG_OK` drops `pg` at that same edge.
- Assertion latency:
  - VDD enters the window before edge E0.
  - `pg` rises after edge E0 + `PG_DLY` (i.e. `PG_DLY + 1` in-window edges).
  - Default 17 edges.
- Deassertion latency: `pg` falls after the first rising edge that samples out-of-window (1 cycle).
- `VDD` changes between edges are invisible; only edge samples matter.
- Reset release: qualification begins on the first edge with reset low.

## Configuration
- `COMPARADOR_HYST_EN` defined:
  - While in `PG_OK`, the window widens to `[VDD_MIN-HYST, VDD_MAX+HYST]` (default 3.6..4.4).
  - `PG_LOW` and `PG_WAIT` use the nominal window.
  - Prevents `pg` chatter near thresholds.
- `COMPARADOR_HYST_EN` undefined:
  - A single fixed window in all states.
  - The `HYST` parameter is unused.

## Structure
- Package `comparador_pkg`:
  - State enum `pg_state_e` (`PG_LOW`, `PG_WAIT`, `PG_OK`).
  - Default threshold constants: `VDD_MIN_DEF` 3.7, `VDD_MAX_DEF` 4.3, `HYST_DEF` 0.1, `PG_DLY_DEF` 16.
- Sub-module `pg_qualifier`:
  - Holds the state machine and counter.
  - Takes `clk`, `arst_n` and a 1-bit `in_win`; outputs `pg`.
- The top does only the real-valued window compare and the hysteresis selection.

## Test plan
- Reset held 20 ns, `VDD = 0`, then released with `VDD = 3.5` for 100 cycles → `pg = 0` throughout.
- `VDD = 4.5` for 100 cycles → `pg = 0` (over-voltage).
- `VDD = 4.1` for 100 cycles → `pg` rises after the 17th edge and stays 1.
- `VDD = 3.8` → `pg` stays 1. Then `VDD = 2.0` → `pg = 0` one edge later. Then `VDD = 4.1` → `pg = 1` after 17 edges.
- Alternating in-window/out-of-window glitches:
  - 4.1 for 10 cycles, 3.5 for 1 cycle, repeated → `pg` never asserts.
  - Boundary values 3.7 and 4.3 → qualify; 3.69 and 4.31 → do not.
- Hysteresis, with `COMPARADOR_HYST_EN`:
  - Reach `PG_OK` at 4.1, then `VDD = 4.35` → `pg` stays 1; `VDD = 4.45` → `pg = 0`.
  - Without the macro, 4.35 drops `pg`.
  - Reset asserted while `pg = 1` → `pg = 0` at the same edge.

Source files
------------

// File: rtl/comparador_pkg.sv
// comparador_pkg: shared state encoding and default thresholds for the
// power-good window comparator.
package comparador_pkg;

    typedef enum logic [1:0] {
        PG_LOW  = 2'd0,
        PG_WAIT = 2'd1,
        PG_OK   = 2'd2
    } pg_state_e;

    localparam shortreal VDD_MIN_DEF = 3.7;
    localparam shortreal VDD_MAX_DEF = 4.3;
    localparam shortreal HYST_DEF    = 0.1;
    localparam int       PG_DLY_DEF  = 16;

endpackage

// File: rtl/pg_qualifier.sv
// pg_qualifier: deglitching state machine. pg asserts only after PG_DLY+1
// consecutive in-window samples; any out-of-window sample drops it.
module pg_qualifier
    import comparador_pkg::*;
#(
    parameter int PG_DLY = PG_DLY_DEF
) (
    input  logic clk,
    input  logic arst_n,
    input  logic in_win,
    output logic pg
);

    localparam logic [7:0] CNT_MAX = 8'(PG_DLY);

    pg_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    // State and counter registers; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (arst_n) begin
            state_q <= PG_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: qualify in-window run length, restart on any dropout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            PG_LOW: begin
                cnt_d = '0;
                if (in_win) begin
                    state_d = PG_WAIT;
                    cnt_d   = 8'd1;
                end
            end
            PG_WAIT: begin
                if (!in_win) begin
                    state_d = PG_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PG_OK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PG_OK: begin
                if (!in_win) begin
                    state_d = PG_LOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = PG_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // pg is a decode of the registered state, so it is glitch-free.
    assign pg = (state_q == PG_OK);

endmodule

// File: rtl/comparador_pg.sv
// comparador_pg: power-good window comparator (behavioural, real-valued VDD).
// Optional feature macro: COMPARADOR_HYST_EN widens the window by HYST while
// pg is asserted.
module comparador_pg
    import comparador_pkg::*;
#(
    parameter shortreal VDD_MIN = VDD_MIN_DEF,
    parameter shortreal VDD_MAX = VDD_MAX_DEF,
    parameter int       PG_DLY  = PG_DLY_DEF,
    parameter shortreal HYST    = HYST_DEF
) (
    input  logic     clk,
    input  logic     arst_n,
    input  shortreal VDD,
    output logic     pg
);

    logic     hyst_sel;
    logic     in_win;
    shortreal win_lo, win_hi;

`ifdef COMPARADOR_HYST_EN
    // pg is high exactly in PG_OK, so it selects the widened window.
    assign hyst_sel = pg;
`else
    assign hyst_sel = 1'b0;
`endif

    // Window compare; NaN fails both compares and is therefore out-of-window.
    always_comb begin
        win_lo = VDD_MIN;
        win_hi = VDD_MAX;
        if (hyst_sel) begin
            win_lo = VDD_MIN - HYST;
            win_hi = VDD_MAX + HYST;
        end
        in_win = (VDD >= win_lo) && (VDD <= win_hi);
    end

    pg_qualifier #(
        .PG_DLY(PG_DLY)
    ) u_qual (
        .clk   (clk),
        .arst_n(arst_n),
        .in_win(in_win),
        .pg    (pg)
    );

endmodule

// File: tb/tb_comparador_pg.sv
// tb_comparador_pg: table-driven and randomized checks of comparador_pg
// against a run-length reference model.
module tb_comparador_pg;

    localparam shortreal M_MIN  = 3.7;
    localparam shortreal M_MAX  = 4.3;
    localparam shortreal M_HYST = 0.1;
    localparam int       M_DLY  = 16;
`ifdef COMPARADOR_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     arst_n;
    shortreal vdd;
    logic     pg;
    logic     pg1;

    always #5 clk = ~clk;

    comparador_pg dut (
        .clk   (clk),
        .arst_n(arst_n),
        .VDD   (vdd),
        .pg    (pg)
    );

    comparador_pg #(.PG_DLY(1)) dut1 (
        .clk   (clk),
        .arst_n(arst_n),
        .VDD   (vdd),
        .pg    (pg1)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned run   = 0;
    bit          exp_pg = 1'b0;

    typedef struct {
        bit          rst;
        shortreal    vdd;
        int unsigned n;
        bit          exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, shortreal v, int unsigned n, bit e);
        vec_t t;
        t.rst = r; t.vdd = v; t.n = n; t.exp = e;
        tbl.push_back(t);
    endfunction

    // Model: pg needs M_DLY+1 consecutive nominal in-window samples; once
    // high it holds while the (possibly widened) window holds.
    function automatic void model_step(bit rst, shortreal v);
        bit nom  = (v >= M_MIN) && (v <= M_MAX);
        bit wide = (v >= M_MIN - M_HYST) && (v <= M_MAX + M_HYST);
        if (!HYST_ON) wide = nom;
        if (rst) begin
            run    = 0;
            exp_pg = 1'b0;
        end else if (exp_pg) begin
            exp_pg = wide;
            run    = 0;
        end else begin
            run    = nom ? run + 1 : 0;
            exp_pg = (run >= M_DLY + 1);
        end
    endfunction

    task automatic check(string name, logic act, bit exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: pg=%b expected %b", name, act, exp);
        end
    endtask

    task automatic step(bit rst, shortreal v, string tag);
        @(negedge clk);
        arst_n = rst;
        vdd    = v;
        @(posedge clk);
        #1;
        model_step(rst, v);
        check(tag, pg, exp_pg);
    endtask

    shortreal vals[12] = '{0.0, 3.5, 3.65, 3.69, 3.7, 3.8, 4.1, 4.3, 4.31, 4.35, 4.45, -1.0};

    initial begin
        real      z;
        shortreal nan_v;
        shortreal v;

        arst_n = 1'b1;
        vdd    = 0.0;

        add(1, 0.0, 2, 0);
        add(0, 3.5, 100, 0);
        add(0, 4.5, 100, 0);
        add(0, 4.1, 16, 0);
        add(0, 4.1, 1, 1);
        add(0, 4.1, 83, 1);
        add(0, 3.8, 10, 1);
        add(0, 2.0, 1, 0);
        add(0, 4.1, 16, 0);
        add(0, 4.1, 1, 1);
        add(0, 2.0, 1, 0);
        for (int g = 0; g < 3; g++) begin
            add(0, 4.1, 10, 0);
            add(0, 3.5, 1, 0);
        end
        add(0, 3.7, 17, 1);
        add(0, 2.0, 1, 0);
        add(0, 4.3, 16, 0);
        add(0, 4.3, 1, 1);
        add(0, 2.0, 1, 0);
        add(0, 3.69, 30, 0);
        add(0, 4.31, 30, 0);
        add(0, 4.1, 17, 1);
        add(0, 4.35, 1, HYST_ON);
        add(0, 4.45, 1, 0);
        add(0, 4.1, 17, 1);
        add(1, 4.1, 1, 0);
        add(0, 4.1, 16, 0);
        add(0, 4.1, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int unsigned k = 0; k < tbl[i].n; k++)
                step(tbl[i].rst, tbl[i].vdd, $sformatf("vec%0d.%0d", i, k));
            check($sformatf("vec%0d_end", i), pg, tbl[i].exp);
        end

        // NaN and negative supply are out-of-window.
        z     = 0.0;
        nan_v = z / z;
        for (int i = 0; i < 17; i++) step(0, 4.1, "pre_nan");
        check("pg_before_nan", pg, 1'b1);
        step(0, nan_v, "nan");
        check("nan_drop", pg, 1'b0);
        for (int i = 0; i < 20; i++) step(0, -4.1, "negative");
        check("negative_end", pg, 1'b0);

        // PG_DLY = 1: exactly one WAIT cycle.
        step(1, 0.0, "d1_rst");
        check("d1_rst_pg", pg1, 1'b0);
        step(0, 4.1, "d1_e0");
        check("d1_after_e0", pg1, 1'b0);
        step(0, 4.1, "d1_e1");
        check("d1_after_e1", pg1, 1'b1);
        step(0, 3.0, "d1_out");
        check("d1_drop", pg1, 1'b0);
        step(0, 4.1, "d1_g");
        step(0, 3.0, "d1_g_out");
        check("d1_glitch", pg1, 1'b0);
        step(0, 4.1, "d1_r0");
        step(0, 4.1, "d1_r1");
        check("d1_requal", pg1, 1'b1);

        // Randomized segments checked cycle by cycle against the model.
        for (int s = 0; s < 80; s++) begin
            int unsigned len;
            if ($urandom_range(0, 14) == 0) step(1, 4.1, "rnd_rst");
            v   = vals[$urandom_range(0, 11)];
            len = ((v >= M_MIN) && (v <= M_MAX)) ? $urandom_range(5, 30) : $urandom_range(1, 6);
            for (int unsigned k = 0; k < len; k++)
                step(0, v, $sformatf("rnd%0d.%0d", s, k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
